// File: rtl/gate_sensor_decoder_if.sv
// Gate sensor decoder bus: raw beam inputs and the decoded pulse/status outputs.
// master = sensor/test side, slave = decoder side.
interface gate_sensor_decoder_if;
  logic sens_a;
  logic sens_b;
  logic inc;
  logic dec;
  logic busy;
  logic err;

  modport master (output sens_a, output sens_b,
                  input  inc, input dec, input busy, input err);
  modport slave  (input  sens_a, input sens_b,
                  output inc, output dec, output busy, output err);
endinterface

// File: rtl/gate_sensor_decoder.sv
// Converts two raw gate beam sensors (A outer, B inner) into single-cycle
// inc/dec pulses per completed vehicle passage, flagging malformed/stalled sequences on err.
module gate_sensor_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  gate_sensor_decoder_if.slave   bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENT1     = 3'd1,
    ENT2     = 3'd2,
    ENT3     = 3'd3,
    EXT1     = 3'd4,
    EXT2     = 3'd5,
    EXT3     = 3'd6,
    WAIT_CLR = 3'd7
  } state_t;

  // Bit 1 = sensor A, bit 0 = sensor B, so filt is the FSM pattern P directly.
  logic [1:0]         sync1, sync2, filt, p_prev;
  logic [1:0][DW-1:0] dcnt;
  logic [TW-1:0]      tcnt, tcnt_n;
  state_t             state, state_n;
  logic               inc_q, dec_q, err_q, busy_q;
  logic               inc_n, dec_n, err_n;
  logic               p_chg, both_flip, fault;

  // Two-flop synchroniser plus per-sensor debounce filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      dcnt  <= '0;
    end else begin
      sync1 <= {bus.sens_a, bus.sens_b};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt[i] <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  // FSM state, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      p_prev <= '0;
      tcnt   <= '0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      p_prev <= filt;
      tcnt   <= tcnt_n;
      inc_q  <= inc_n;
      dec_q  <= dec_n;
      err_q  <= err_n;
      busy_q <= (state_n != IDLE);
    end
  end

  assign p_chg     = (filt != p_prev);
  assign both_flip = ((filt ^ p_prev) == 2'b11);

  // Next-state: a double flip is always illegal; every single flip maps to a legal move.
  always_comb begin
    state_n = state;
    inc_n   = 1'b0;
    dec_n   = 1'b0;
    err_n   = 1'b0;
    fault   = 1'b0;

    if (state == WAIT_CLR) begin
      if (filt == 2'b00) state_n = IDLE;
    end else if (p_chg && both_flip) begin
      fault = 1'b1;
    end else if (p_chg) begin
      unique case (state)
        IDLE: if (filt == 2'b10) state_n = ENT1;
              else if (filt == 2'b01) state_n = EXT1;
        ENT1: state_n = (filt == 2'b11) ? ENT2 : IDLE;
        ENT2: state_n = (filt == 2'b01) ? ENT3 : ENT1;
        ENT3: begin
          if (filt == 2'b00) begin
            state_n = IDLE;
            inc_n   = 1'b1;
          end else begin
            state_n = ENT2;
          end
        end
        EXT1: state_n = (filt == 2'b11) ? EXT2 : IDLE;
        EXT2: state_n = (filt == 2'b10) ? EXT3 : EXT1;
        EXT3: begin
          if (filt == 2'b00) begin
            state_n = IDLE;
            dec_n   = 1'b1;
          end else begin
            state_n = EXT2;
          end
        end
        default: state_n = state;
      endcase
    end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      fault = 1'b1;
    end

    if (fault) begin
      state_n = WAIT_CLR;
      err_n   = 1'b1;
    end

    if (state_n != state || state == IDLE || state == WAIT_CLR) tcnt_n = '0;
    else                                                        tcnt_n = tcnt + TW'(1);
  end

  assign bus.inc  = inc_q;
  assign bus.dec  = dec_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule
